rf_key_writer: RTL and testbench

Debounced pushbutton write sequencer feeding the register file write port on the FPGA board. It synchronizes a raw active-low write key and the switch-selected address/data, then issues exactly one single-cycle `WEN` pulse per debounced press. `wsel`/`wdat` are held stable around and after that pulse. It sits directly upstream of the register file's `wsel`, `wdat` and `WEN` inputs, replacing a direct key-to-`WEN` connection that writes on every cycle the key is held.

---
 rtl/rf_key_writer.sv | 105 ++++++++++
 tb/tb_rf_key_writer.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/rf_key_writer.sv
// Debounced pushbutton write sequencer: one single-cycle WEN per accepted key press,
// with wsel/wdat captured from synchronized switches on acceptance and held until the next press.
module rf_key_writer #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int DW              = 32
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          key_n,
    input  logic [4:0]    wsel_in,
    input  logic [DW-1:0] wdat_in,
    output logic [4:0]    wsel,
    output logic [DW-1:0] wdat,
    output logic          WEN,
    output logic          busy,
    output logic [7:0]    write_count
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_PRESS_WAIT = 3'd1;
    localparam logic [2:0] S_WRITE      = 3'd2;
    localparam logic [2:0] S_HELD       = 3'd3;
    localparam logic [2:0] S_REL_WAIT   = 3'd4;

    logic [2:0]    state;
    logic [CW-1:0] cnt;
    logic          key_m, key_s;
    logic [4:0]    wsel_m, wsel_s;
    logic [DW-1:0] wdat_m, wdat_s;

    // Key sync resets to 1 so a reset never looks like a press on its own.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            key_m  <= 1'b1;
            key_s  <= 1'b1;
            wsel_m <= '0;
            wsel_s <= '0;
            wdat_m <= '0;
            wdat_s <= '0;
        end else begin
            key_m  <= key_n;
            key_s  <= key_m;
            wsel_m <= wsel_in;
            wsel_s <= wsel_m;
            wdat_m <= wdat_in;
            wdat_s <= wdat_m;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state       <= S_IDLE;
            cnt         <= '0;
            wsel        <= '0;
            wdat        <= '0;
            WEN         <= 1'b0;
            write_count <= '0;
        end else begin
            WEN <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (!key_s) begin
                        state <= S_PRESS_WAIT;
                        cnt   <= '0;
                    end
                end
                S_PRESS_WAIT: begin
                    if (key_s) begin
                        state <= S_IDLE;
                    end else if (cnt == CNT_LAST) begin
                        // WEN and the count are registered alongside entry into WRITE
                        state       <= S_WRITE;
                        wsel        <= wsel_s;
                        wdat        <= wdat_s;
                        WEN         <= 1'b1;
                        write_count <= write_count + 8'd1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_WRITE: state <= S_HELD;
                S_HELD: begin
                    if (key_s) begin
                        state <= S_REL_WAIT;
                        cnt   <= '0;
                    end
                end
                S_REL_WAIT: begin
                    if (!key_s) begin
                        state <= S_HELD;
                    end else if (cnt == CNT_LAST) begin
                        state <= S_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign busy = (state != S_IDLE);
endmodule

// File: tb/tb_rf_key_writer.sv
// Directed bench for rf_key_writer: expected writes are queued when a press is driven
// and matched against observed WEN pulses (select, data and exact cycle).
module tb_rf_key_writer;
    localparam int D  = 4;
    localparam int DW = 8;

    logic          CLK = 1'b0;
    logic          RST;
    logic          key_n;
    logic [4:0]    wsel_in;
    logic [DW-1:0] wdat_in;
    logic [4:0]    wsel;
    logic [DW-1:0] wdat;
    logic          WEN;
    logic          busy;
    logic [7:0]    write_count;

    typedef struct {
        logic [4:0]    sel;
        logic [DW-1:0] dat;
        int            cyc;
    } wr_t;

    wr_t exp_q[$];
    wr_t obs_q[$];
    int  rd    = 0;
    int  cyc   = 0;
    int  total = 0;
    int  bad   = 0;

    rf_key_writer #(.DEBOUNCE_CYCLES(D), .DW(DW)) dut (
        .CLK(CLK), .RST(RST), .key_n(key_n), .wsel_in(wsel_in), .wdat_in(wdat_in),
        .wsel(wsel), .wdat(wdat), .WEN(WEN), .busy(busy), .write_count(write_count)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    // Every observed WEN pulse, sampled mid-cycle
    always @(negedge CLK) begin
        if (WEN !== 1'b0) obs_q.push_back('{wsel, wdat, cyc});
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge CLK);
    endtask

    // Drive a press at a negedge; edge 1 is the next posedge, WEN follows edge D+3.
    task automatic press_expect();
        exp_q.push_back('{wsel_in, wdat_in, cyc + D + 3});
        key_n = 1'b0;
    endtask

    task automatic drain();
        wr_t e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (rd < obs_q.size()) begin
                chk("wen_sel", 32'(obs_q[rd].sel), 32'(e.sel));
                chk("wen_dat", 32'(obs_q[rd].dat), 32'(e.dat));
                chk("wen_cyc", 32'(obs_q[rd].cyc), 32'(e.cyc));
                rd++;
            end else begin
                chk("wen_missing", 32'(obs_q.size()), 32'(rd + 1));
            end
        end
        chk("wen_extra", 32'(obs_q.size()), 32'(rd));
    endtask

    initial begin
        RST = 1'b1; key_n = 1'b1; wsel_in = '0; wdat_in = '0;
        tick(3);
        chk("rst_wsel", 32'(wsel), 0);
        chk("rst_wdat", 32'(wdat), 0);
        chk("rst_wen", 32'(WEN), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_count", 32'(write_count), 0);
        RST = 1'b0;
        tick(20);
        drain();
        chk("idle_busy", 32'(busy), 0);

        // Clean press, then hold long
        wsel_in = 5'd5; wdat_in = 8'd3;
        tick(1);
        press_expect();
        tick(100);
        drain();
        chk("press_wsel", 32'(wsel), 5);
        chk("press_wdat", 32'(wdat), 3);
        chk("press_count", 32'(write_count), 1);
        chk("held_busy", 32'(busy), 1);

        // Switch changes while held and after release must not reach outputs
        wsel_in = 5'd9; wdat_in = 8'd7;
        tick(10);
        chk("hold_wsel", 32'(wsel), 5);
        chk("hold_wdat", 32'(wdat), 3);
        key_n = 1'b1;
        tick(20);
        chk("rel_busy", 32'(busy), 0);
        chk("rel_wsel", 32'(wsel), 5);
        chk("rel_wdat", 32'(wdat), 3);

        // Bouncy press: never D+1 consecutive lows
        for (int i = 0; i < 5; i++) begin
            key_n = 1'b0; tick(3);
            key_n = 1'b1; tick(1);
        end
        tick(20);
        drain();
        chk("bounce_count", 32'(write_count), 1);
        chk("bounce_busy", 32'(busy), 0);

        // Next accepted press picks up the new switches
        press_expect();
        tick(20);
        drain();
        chk("p2_wsel", 32'(wsel), 9);
        chk("p2_wdat", 32'(wdat), 7);
        chk("p2_count", 32'(write_count), 2);

        // Release with a low glitch mid RELEASE_WAIT, then full release and a new press
        key_n = 1'b1; tick(4);
        key_n = 1'b0; tick(2);
        key_n = 1'b1; tick(3);
        chk("relglitch_busy", 32'(busy), 1);
        tick(20);
        chk("relglitch_idle", 32'(busy), 0);
        drain();
        wsel_in = 5'd12; wdat_in = 8'h5a;
        tick(1);
        press_expect();
        tick(20);
        key_n = 1'b1;
        tick(20);
        drain();
        chk("p3_count", 32'(write_count), 3);
        chk("p3_wsel", 32'(wsel), 12);

        // Wrap: 253 more presses brings the count to 256
        for (int i = 0; i < 253; i++) begin
            wsel_in = 5'(i); wdat_in = 8'(i * 3);
            tick(1);
            press_expect();
            tick(12);
            key_n = 1'b1;
            tick(12);
        end
        drain();
        chk("wrap_count", 32'(write_count), 0);

        // Reset during PRESS_WAIT, key still held after release counts as a fresh press
        wsel_in = 5'd17; wdat_in = 8'ha5;
        tick(1);
        key_n = 1'b0;
        tick(4);
        chk("pw_busy", 32'(busy), 1);
        RST = 1'b1;
        #1;
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_wen", 32'(WEN), 0);
        tick(3);
        RST = 1'b0;
        exp_q.push_back('{wsel_in, wdat_in, cyc + D + 3});
        tick(20);
        drain();
        chk("post_rst_count", 32'(write_count), 1);
        chk("post_rst_wsel", 32'(wsel), 17);
        chk("post_rst_wdat", 32'(wdat), 32'ha5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
